multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM sequencing a multi-cycle RV32I datapath: FETCH/DECODE/EXEC/MEM/WB.
//  Shares one memory port between instruction fetch and load/store via a req/ready handshake.
//  Drives the same ALUOp/ALUSrc/MemtoReg/RegWrite semantics as the single-cycle main decoder.
//  Supports LW, SW, I-type ALU and R-type; all other opcodes halt with an illegal flag.
// PARAMETERS
//  TIMEOUT_CYC  16  consecutive mem_ready=0 cycles while mem_req=1 before halting; 0 disables
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  opcode      in   7  instr[6:0] from instruction register; sampled in DECODE
//  mem_ready   in   1  memory accepted/completed current request this cycle
//  mem_req     out  1  memory request; held until mem_ready
//  mem_we      out  1  write strobe; only ever high together with mem_req
//  mem_src     out  1  0 = address from PC (fetch), 1 = address from ALU result
//  ir_write    out  1  load instruction register (1-cycle pulse)
//  pc_write    out  1  PC <= PC+4 (1-cycle pulse)
//  alu_src     out  1  0 = rs2, 1 = immediate
//  alu_op      out  2  00 I-type, 01 LW/SW address add, 10 R-type
//  reg_write   out  1  register file write enable (1-cycle pulse)
//  mem_to_reg  out  1  1 = write-back data from memory, 0 = ALU result
//  illegal     out  1  sticky: unsupported opcode decoded
//  timeout     out  1  sticky: memory timeout occurred
//  state       out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, op_q=0, wait counter=0, illegal=timeout=0; every output 0.
//  IDLE: all strobes 0; next FETCH unconditionally.
//  FETCH: mem_req=1, mem_src=0. mem_ready=1 -> ir_write=1, pc_write=1 same cycle; next DECODE.
//  DECODE: op_q<=opcode. 0000011 LW, 0100011 SW, 0010011 I, 0110011 R -> EXEC; else -> HALT, illegal<=1.
//  EXEC: alu_src/alu_op from op_q: LW/SW 1/01, I 1/00, R 0/10. LW/SW -> MEM; I/R -> WB.
//  MEM: mem_req=1, mem_src=1, mem_we=(op_q==SW). On mem_ready: SW -> FETCH, LW -> WB.
//  WB: reg_write=1, mem_to_reg=(op_q==LW); next FETCH.
//  alu_src/alu_op hold EXEC values through MEM and WB; 0/00 in IDLE, FETCH, DECODE, HALT.
//  HALT: all strobes 0; terminal until rst_n low. Flags keep value.
//  Outputs decoded from state + op_q only (Moore); mem_ready affects next state, ir_write, pc_write.
//  mem_ready ignored when mem_req=0.
//  Wait counter: clears on state entry and on mem_ready; +1 per FETCH/MEM cycle with mem_ready=0.
//   Reaching TIMEOUT_CYC -> next HALT, timeout<=1. Width $clog2(TIMEOUT_CYC+1); saturates, never wraps.
//  Latency, zero-wait memory: R/I 4 cycles, SW 4, LW 5 (FETCH to next FETCH).
//  Each memory wait cycle adds exactly one cycle.
//  Reset mid-operation: outputs drop to 0 asynchronously; no partial write; restarts via IDLE.
// TESTING
//  1 Reset, opcode=0110011, mem_ready=1 -> IDLE,FETCH,DECODE,EXEC,WB,FETCH; WB reg_write=1 alu_op=10 alu_src=0.
//  2 LW, mem_ready low 3 cycles in MEM -> mem_req,mem_src=1 held 4 cycles, mem_we=0; WB mem_to_reg=1; 8 cycles.
//  3 SW, mem_ready=1 -> MEM mem_we=1 alu_op=01 alu_src=1; back to FETCH; reg_write never 1.
//  4 opcode=1100011 -> HALT after DECODE, illegal=1; no further mem_req for 20 cycles.
//  5 TIMEOUT_CYC=4, mem_ready=0 in FETCH -> 4 FETCH cycles, then HALT, timeout=1, mem_req=0.
//  6 rst_n=0 mid-MEM of SW -> mem_req,mem_we=0 before next clk edge; state=0; flags 0; resumes at FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_if
// Brief    : Shared memory-port handshake between the controller and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_src,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Moore FSM sequencing a multi-cycle RV32I datapath over one memory port.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [6:0]                     opcode,
    multicycle_controller_if.master        mem,
    output logic                           ir_write,
    output logic                           pc_write,
    output logic                           alu_src,
    output logic [1:0]                     alu_op,
    output logic                           reg_write,
    output logic                           mem_to_reg,
    output logic                           illegal,
    output logic                           timeout,
    output logic [2:0]                     state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [6:0] c_op_lw = 7'b0000011;
    localparam logic [6:0] c_op_sw = 7'b0100011;
    localparam logic [6:0] c_op_i  = 7'b0010011;
    localparam logic [6:0] c_op_r  = 7'b0110011;
    localparam int         c_cnt_w = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t               r_state;
    state_t               w_next;
    logic [6:0]           r_op;
    logic [6:0]           w_next_op;
    logic [c_cnt_w-1:0]   r_wait;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic                 r_mem_src;
    logic                 r_alu_src;
    logic [1:0]           r_alu_op;
    logic                 r_reg_write;
    logic                 r_mem_to_reg;
    logic                 r_illegal;
    logic                 r_timeout;
    logic                 w_stall;
    logic                 w_timeout_hit;
    logic                 w_legal;
    logic                 w_alu_phase;

    // {alu_src, alu_op} for a decoded opcode
    function automatic logic [2:0] alu_ctrl(input logic [6:0] op);
        if (op == c_op_lw || op == c_op_sw) return 3'b101;
        else if (op == c_op_i)              return 3'b100;
        else                                return 3'b010;
    endfunction

    assign w_stall       = ((r_state == FETCH) || (r_state == MEM)) && !mem.mem_ready;
    assign w_timeout_hit = (TIMEOUT_CYC != 0) && w_stall && ((int'(r_wait) + 1) >= TIMEOUT_CYC);
    assign w_legal       = (opcode == c_op_lw) || (opcode == c_op_sw) ||
                           (opcode == c_op_i)  || (opcode == c_op_r);
    assign w_alu_phase   = (w_next == EXEC) || (w_next == MEM) || (w_next == WB);

    always_comb begin
        w_next    = r_state;
        w_next_op = r_op;
        case (r_state)
            IDLE:    w_next = FETCH;
            FETCH: begin
                if (mem.mem_ready)      w_next = DECODE;
                else if (w_timeout_hit) w_next = HALT;
            end
            DECODE: begin
                w_next_op = opcode;
                w_next    = w_legal ? EXEC : HALT;
            end
            EXEC:    w_next = ((r_op == c_op_lw) || (r_op == c_op_sw)) ? MEM : WB;
            MEM: begin
                if (mem.mem_ready)      w_next = (r_op == c_op_sw) ? FETCH : WB;
                else if (w_timeout_hit) w_next = HALT;
            end
            WB:      w_next = FETCH;
            default: w_next = HALT;
        endcase
    end

    // Moore outputs are registered from the next state so they change only with state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_wait       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_src    <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= 2'b00;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_illegal    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_op    <= w_next_op;
            if (w_stall && (w_next == r_state)) begin
                if (r_wait != '1) r_wait <= r_wait + c_cnt_w'(1);
            end else begin
                r_wait <= '0;
            end
            if ((r_state == DECODE) && !w_legal) r_illegal <= 1'b1;
            if (w_timeout_hit)                   r_timeout <= 1'b1;
            r_mem_req    <= (w_next == FETCH) || (w_next == MEM);
            r_mem_src    <= (w_next == MEM);
            r_mem_we     <= (w_next == MEM) && (w_next_op == c_op_sw);
            r_reg_write  <= (w_next == WB);
            r_mem_to_reg <= (w_next == WB) && (w_next_op == c_op_lw);
            if (w_alu_phase) {r_alu_src, r_alu_op} <= alu_ctrl(w_next_op);
            else             {r_alu_src, r_alu_op} <= 3'b000;
        end
    end

    assign mem.mem_req = r_mem_req;
    assign mem.mem_we  = r_mem_we;
    assign mem.mem_src = r_mem_src;
    assign ir_write    = (r_state == FETCH) && mem.mem_ready;
    assign pc_write    = (r_state == FETCH) && mem.mem_ready;
    assign alu_src     = r_alu_src;
    assign alu_op      = r_alu_op;
    assign reg_write   = r_reg_write;
    assign mem_to_reg  = r_mem_to_reg;
    assign illegal     = r_illegal;
    assign timeout     = r_timeout;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Randomized bench comparing the controller to a step-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int         TO     = 4;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_HALT = 6;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [6:0]  opcode = '0;
    logic        ir_write, pc_write, alu_src, reg_write, mem_to_reg, illegal, timeout;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [11:0] dut_outs;

    multicycle_controller_if mem_if ();

    multicycle_controller #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem        (mem_if),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .timeout    (timeout),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign dut_outs = {mem_if.mem_req, mem_if.mem_we, mem_if.mem_src, ir_write, pc_write,
                       alu_src, alu_op, reg_write, mem_to_reg, illegal, timeout};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the remaining steps of the current instruction as a queue
    int         plan[$];
    logic [6:0] m_op;
    int         m_wait;
    bit         m_halt, m_ill, m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        plan.delete();
        plan.push_back(S_IDLE);
        m_op   = '0;
        m_wait = 0;
        m_halt = 0;
        m_ill  = 0;
        m_to   = 0;
    endtask

    // Called away from the rising edge; returns at the following falling edge.
    task automatic step(input logic [6:0] op_in, input logic rdy);
        int         cur;
        logic       as;
        logic [1:0] ao;
        logic       is_lw, is_sw;
        logic [11:0] want;
        opcode           = op_in;
        mem_if.mem_ready = rdy;
        #1;
        cur   = m_halt ? S_HALT : plan[0];
        is_lw = (m_op == OP_LW);
        is_sw = (m_op == OP_SW);
        as    = 1'b0;
        ao    = 2'b00;
        if (cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
            if (is_lw || is_sw)    begin as = 1'b1; ao = 2'b01; end
            else if (m_op == OP_I) begin as = 1'b1; ao = 2'b00; end
            else                   begin as = 1'b0; ao = 2'b10; end
        end
        want = {(cur == S_FETCH) || (cur == S_MEM), (cur == S_MEM) && is_sw, cur == S_MEM,
                (cur == S_FETCH) && rdy, (cur == S_FETCH) && rdy, as, ao,
                cur == S_WB, (cur == S_WB) && is_lw, m_ill, m_to};
        check("state", 32'(state), 32'(cur));
        check("outs", 32'(dut_outs), 32'(want));
        if (!m_halt) begin
            case (cur)
                S_IDLE: begin
                    void'(plan.pop_front());
                    plan.push_back(S_FETCH);
                end
                S_FETCH, S_MEM: begin
                    if (rdy) begin
                        void'(plan.pop_front());
                        m_wait = 0;
                        if (cur == S_FETCH) plan.push_back(S_DECODE);
                    end else begin
                        m_wait++;
                        if (m_wait >= TO) begin m_halt = 1; m_to = 1; end
                    end
                end
                S_DECODE: begin
                    void'(plan.pop_front());
                    if (op_in == OP_LW || op_in == OP_SW || op_in == OP_I || op_in == OP_R) begin
                        m_op = op_in;
                        plan.push_back(S_EXEC);
                        if (op_in == OP_LW || op_in == OP_SW) plan.push_back(S_MEM);
                        if (op_in != OP_SW) plan.push_back(S_WB);
                    end else begin
                        m_halt = 1;
                        m_ill  = 1;
                    end
                end
                default: void'(plan.pop_front());
            endcase
            if (!m_halt && plan.size() == 0) plan.push_back(S_FETCH);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        mem_if.mem_ready = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_outs", 32'(dut_outs), 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [6:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return OP_LW;
            2, 3:    return OP_SW;
            4, 5:    return OP_I;
            6, 7:    return OP_R;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        int cyc;
        int waits;
        logic rdy;
        mem_if.mem_ready = 1'b0;
        model_reset();

        // R-type, zero-wait memory
        do_reset();
        repeat (6) step(OP_R, 1'b1);

        // LW with three wait cycles in MEM: FETCH to next FETCH takes 8 cycles
        do_reset();
        step(OP_LW, 1'b1);
        cyc   = 0;
        waits = 0;
        do begin
            rdy = !((state == 3'(S_MEM)) && (waits < 3));
            if (!rdy) waits++;
            step(OP_LW, rdy);
            cyc++;
        end while ((state != 3'(S_FETCH)) && (cyc < 20));
        check("lw_cycles", 32'(cyc), 32'd8);

        // SW, zero-wait memory
        do_reset();
        repeat (7) step(OP_SW, 1'b1);

        // Unsupported opcode halts after DECODE
        do_reset();
        step(OP_BR, 1'b1);
        step(OP_BR, 1'b1);
        step(OP_BR, 1'b1);
        repeat (20) step(7'($urandom), 1'($urandom));

        // Fetch never acknowledged: timeout after TO cycles
        do_reset();
        step(OP_R, 1'b0);
        repeat (TO + 4) step(OP_R, 1'b0);

        // Asynchronous reset in the middle of a store's MEM phase
        do_reset();
        step(OP_SW, 1'b1);
        step(OP_SW, 1'b1);
        step(OP_SW, 1'b1);
        step(OP_SW, 1'b1);
        step(OP_SW, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(mem_if.mem_req), 32'd0);
        check("arst_we", 32'(mem_if.mem_we), 32'd0);
        check("arst_state", 32'(state), 32'(S_IDLE));
        check("arst_flags", 32'({illegal, timeout}), 32'd0);
        model_reset();
        rst_n = 1'b1;
        repeat (8) step(OP_I, 1'b1);

        // Randomized traffic
        for (int round = 0; round < 30; round++) begin
            do_reset();
            for (int k = 0; k < 60; k++) step(rand_op(), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
